// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and opcode field layout.
// The decoder imports the same field constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_ARG,
    FETCH_DATA,
    ISSUE
  } fetch_state_t;

  localparam int         OPC_ONE_ARG_BIT = 7;
  localparam int         OPC_SRC_LSB     = 1;
  localparam logic [1:0] SRC_DATA        = 2'b01;
  localparam logic [1:0] OPC_CLASS_MEM   = 2'b10;

  function automatic logic has_arg(input logic [7:0] opc);
    return opc[OPC_ONE_ARG_BIT];
  endfunction

  // Memory-class opcode whose source field selects a data byte at {8'h00, arg}.
  function automatic logic is_data_src(input logic [7:0] opc);
    return (opc[7:6] == OPC_CLASS_MEM) && (opc[OPC_SRC_LSB +: 2] == SRC_DATA);
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Fetch pointer register: reset value, increment after each instruction-byte
// read, and load of a branch target from the execute stage.
module fetch_pc #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        load,
  input  logic [15:0] load_pc,
  output logic [15:0] fptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fptr <= RESET_PC;
    end else if (load) begin
      fptr <= load_pc;
    end else if (inc) begin
      fptr <= fptr + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads opcode, optional argument and optional data
// byte over an 8-bit bus, then presents the assembled instruction to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] inst,
  output logic [7:0]  data,
  output logic [15:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  // Handshakes: a memory read transfers on a cycle with mem_rd && mem_ready,
  // an instruction transfers on a cycle with inst_valid && inst_ready; the
  // producer holds its address/payload stable until that cycle.
  fetch_state_t state;
  logic [15:0]  fptr;
  logic         ptr_inc;
  logic         ptr_load;

  assign ptr_inc  = mem_ready && ((state == FETCH_OP) || (state == FETCH_ARG));
  assign ptr_load = (state == ISSUE) && inst_ready && redirect_valid;

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk     (clk),
    .rst     (rst),
    .inc     (ptr_inc),
    .load    (ptr_load),
    .load_pc (redirect_pc),
    .fptr    (fptr)
  );

  // Bus controls decode only registered state, so mem_ready never feeds them.
  assign mem_rd     = (state == FETCH_OP) || (state == FETCH_ARG) || (state == FETCH_DATA);
  assign mem_addr   = (state == FETCH_DATA) ? {8'h00, inst[7:0]} : fptr;
  assign inst_valid = (state == ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      inst  <= 16'h0000;
      data  <= 8'h00;
      pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= FETCH_OP;
        FETCH_OP: begin
          if (mem_ready) begin
            inst[15:8] <= mem_rdata;
            pc         <= fptr;
            if (!has_arg(mem_rdata)) begin
              inst[7:0] <= 8'h00;
              data      <= 8'h00;
              state     <= ISSUE;
            end else begin
              state <= FETCH_ARG;
            end
          end
        end
        FETCH_ARG: begin
          if (mem_ready) begin
            inst[7:0] <= mem_rdata;
            if (is_data_src(inst[15:8])) begin
              state <= FETCH_DATA;
            end else begin
              data  <= 8'h00;
              state <= ISSUE;
            end
          end
        end
        FETCH_DATA: begin
          if (mem_ready) begin
            data  <= mem_rdata;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (inst_ready) state <= FETCH_OP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset/latency vector table, redirect and wrap/reset
// sequences, and randomized streams checked against a transaction-level model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance with default RESET_PC
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic [15:0] inst;
  logic [7:0]  data;
  logic [15:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  // instance with RESET_PC = 16'hFFFF
  logic        rst_w;
  logic [15:0] mem_addr_w;
  logic        mem_rd_w;
  logic        mem_ready_w;
  logic [7:0]  mem_rdata_w;
  logic [15:0] inst_w;
  logic [7:0]  data_w;
  logic [15:0] pc_w;
  logic        inst_valid_w;
  logic        inst_ready_w;
  logic        redirect_valid_w;
  logic [15:0] redirect_pc_w;

  logic [7:0] mem [0:65535];
  assign mem_rdata   = mem[mem_addr];
  assign mem_rdata_w = mem[mem_addr_w];

  fetch_unit dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .inst(inst), .data(data),
    .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst(rst_w), .mem_addr(mem_addr_w), .mem_rd(mem_rd_w),
    .mem_ready(mem_ready_w), .mem_rdata(mem_rdata_w), .inst(inst_w), .data(data_w),
    .pc(pc_w), .inst_valid(inst_valid_w), .inst_ready(inst_ready_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] m_ptr;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  arg;
    logic [7:0]  dbyte;
    logic [15:0] e_inst;
    logic [7:0]  e_data;
    int          e_lat;
    logic [15:0] e_next;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_a();
    rst = 1'b1;
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    check("reset mem_rd", mem_rd, 0);
    check("reset mem_addr", mem_addr, 16'h0000);
    check("reset inst", inst, 16'h0000);
    check("reset data", data, 8'h00);
    check("reset pc", pc, 16'h0000);
    check("reset inst_valid", inst_valid, 0);
    rst = 1'b0;
    #1;
    check("mem_rd first cycle after reset", mem_rd, 0);
  endtask

  task automatic wait_valid(input string name);
    int cnt = 0;
    while (!inst_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!inst_valid) check(name, 0, 1);
  endtask

  // Transaction-level reference: decode the next instruction straight from
  // memory at the model pointer and list the byte addresses it must read.
  task automatic score();
    int opi, argi, di;
    logic [15:0] e_pc;
    exp_q.delete();
    e_pc = m_ptr;
    opi = mem[m_ptr];
    exp_q.push_back(m_ptr);
    m_ptr = m_ptr + 16'd1;
    argi = 0;
    di = 0;
    if (opi >= 128) begin
      exp_q.push_back(m_ptr);
      argi = mem[m_ptr];
      m_ptr = m_ptr + 16'd1;
      if (opi / 64 == 2 && (opi / 2) % 4 == 1) begin
        exp_q.push_back(16'(argi));
        di = mem[16'(argi)];
      end
    end
    check("stream pc", pc, e_pc);
    check("stream inst", inst, 32'(opi * 256 + argi));
    check("stream data", data, 32'(di));
    check("stream read count", rd_q.size(), exp_q.size());
    for (int k = 0; k < rd_q.size() && k < exp_q.size(); k++)
      check("stream read addr", rd_q[k], exp_q[k]);
    rd_q.delete();
    if (redirect_valid) m_ptr = redirect_pc;
  endtask

  task automatic run_stream(input int n_hs, input bit det);
    int hs = 0, cyc = 0, mw, iw;
    logic p_rd, p_rdy, p_v, p_ir;
    logic [15:0] p_addr, p_inst, p_pc;
    logic [7:0] p_data;
    reset_a();
    m_ptr = 16'h0000;
    rd_q.delete();
    mw = det ? 3 : $urandom_range(0, 3);
    iw = det ? 2 : $urandom_range(0, 2);
    p_rd = 0; p_rdy = 0; p_v = 0; p_ir = 0;
    p_addr = 0; p_inst = 0; p_pc = 0; p_data = 0;
    while (hs < n_hs && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (p_rd && !p_rdy) begin
        check("mem_rd hold", mem_rd, 1);
        check("mem_addr hold", mem_addr, p_addr);
      end
      if (p_v && !p_ir) begin
        check("inst_valid hold", inst_valid, 1);
        check("inst hold", inst, p_inst);
        check("data hold", data, p_data);
        check("pc hold", pc, p_pc);
      end
      if (mem_rd) begin
        if (mw == 0) begin
          mem_ready = 1'b1;
          mw = det ? 3 : $urandom_range(0, 3);
        end else begin
          mem_ready = 1'b0;
          mw--;
        end
      end else begin
        mem_ready = det ? 1'b0 : 1'($urandom_range(0, 1));
      end
      if (inst_valid) begin
        if (iw == 0) begin
          inst_ready = 1'b1;
          iw = det ? 2 : $urandom_range(0, 2);
        end else begin
          inst_ready = 1'b0;
          iw--;
        end
      end else begin
        inst_ready = det ? 1'b0 : 1'($urandom_range(0, 1));
      end
      redirect_valid = det ? 1'b0 : ($urandom_range(0, 3) == 0);
      redirect_pc = 16'($urandom_range(0, 65535));
      if (mem_rd && mem_ready) rd_q.push_back(mem_addr);
      if (inst_valid && inst_ready) begin
        hs++;
        score();
      end
      p_rd = mem_rd; p_rdy = mem_ready; p_addr = mem_addr;
      p_v = inst_valid; p_ir = inst_ready;
      p_inst = inst; p_data = data; p_pc = pc;
    end
    if (hs < n_hs) check("stream handshake timeout", hs, n_hs);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    rst_w = 1'b1;
    mem_ready = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    mem_ready_w = 1'b1;
    inst_ready_w = 1'b0;
    redirect_valid_w = 1'b0;
    redirect_pc_w = 16'h0000;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(0, 255));

    // op, arg, data byte at {00,arg}, expected inst, data, latency, next opcode address
    vecs[0] = '{8'h00, 8'h11, 8'h00, 16'h0000, 8'h00, 1, 16'h0001};
    vecs[1] = '{8'h7F, 8'h22, 8'h99, 16'h7F00, 8'h00, 1, 16'h0001};
    vecs[2] = '{8'h88, 8'h05, 8'h66, 16'h8805, 8'h00, 2, 16'h0002};
    vecs[3] = '{8'h82, 8'h40, 8'hA5, 16'h8240, 8'hA5, 3, 16'h0002};
    vecs[4] = '{8'hC2, 8'h10, 8'h5A, 16'hC210, 8'h00, 2, 16'h0002};
    vecs[5] = '{8'h86, 8'h20, 8'h33, 16'h8620, 8'h00, 2, 16'h0002};
    vecs[6] = '{8'hA2, 8'h30, 8'h7E, 16'hA230, 8'h7E, 3, 16'h0002};
    vecs[7] = '{8'hBB, 8'h50, 8'h44, 16'hBB50, 8'h44, 3, 16'h0002};
    vecs[8] = '{8'h84, 8'h60, 8'h12, 16'h8460, 8'h00, 2, 16'h0002};

    for (int i = 0; i < 9; i++) begin
      mem[0] = vecs[i].op;
      mem[1] = vecs[i].arg;
      mem[{8'h00, vecs[i].arg}] = vecs[i].dbyte;
      reset_a();
      @(negedge clk);
      check("first mem_rd", mem_rd, 1);
      check("first mem_addr", mem_addr, 16'h0000);
      cnt = 0;
      while (!inst_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check("vec latency", cnt, vecs[i].e_lat);
      check("vec inst", inst, vecs[i].e_inst);
      check("vec data", data, vecs[i].e_data);
      check("vec pc", pc, 16'h0000);
      @(negedge clk);
      check("vec next mem_rd", mem_rd, 1);
      check("vec next mem_addr", mem_addr, vecs[i].e_next);
    end

    // Branch redirect, then a redirect pulse during FETCH_ARG that must be ignored.
    mem[0] = 8'h88; mem[1] = 8'h05;
    mem[16'h0100] = 8'h90; mem[16'h0101] = 8'h07;
    reset_a();
    wait_valid("redirect first valid timeout");
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redirect mem_rd", mem_rd, 1);
    check("redirect mem_addr", mem_addr, 16'h0100);
    @(negedge clk);
    check("arg read after redirect", mem_addr, 16'h0101);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("redirected inst_valid", inst_valid, 1);
    check("redirected inst", inst, 16'h9007);
    check("redirected pc", pc, 16'h0100);
    @(negedge clk);
    check("stray redirect ignored", mem_addr, 16'h0102);

    run_stream(12, 1'b1);
    run_stream(300, 1'b0);

    // Wrap from RESET_PC = FFFF, then asynchronous reset while a read is pending.
    mem[16'hFFFF] = 8'h88;
    mem[16'h0000] = 8'h05;
    @(negedge clk);
    check("wrap reset mem_addr", mem_addr_w, 16'hFFFF);
    check("wrap reset pc", pc_w, 16'hFFFF);
    rst_w = 1'b0;
    #1;
    check("wrap mem_rd after reset", mem_rd_w, 0);
    @(negedge clk);
    check("wrap op mem_rd", mem_rd_w, 1);
    check("wrap op addr", mem_addr_w, 16'hFFFF);
    @(negedge clk);
    check("wrap arg addr", mem_addr_w, 16'h0000);
    @(negedge clk);
    check("wrap inst_valid", inst_valid_w, 1);
    check("wrap inst", inst_w, 16'h8805);
    check("wrap pc", pc_w, 16'hFFFF);
    inst_ready_w = 1'b1;
    @(negedge clk);
    check("wrap next addr", mem_addr_w, 16'h0001);
    check("wrap next mem_rd", mem_rd_w, 1);
    inst_ready_w = 1'b0;
    mem_ready_w = 1'b0;
    #2;
    rst_w = 1'b1;
    #1;
    check("mid-fetch reset mem_rd", mem_rd_w, 0);
    check("mid-fetch reset mem_addr", mem_addr_w, 16'hFFFF);
    check("mid-fetch reset inst_valid", inst_valid_w, 0);
    check("mid-fetch reset inst", inst_w, 16'h0000);
    check("mid-fetch reset data", data_w, 8'h00);
    check("mid-fetch reset pc", pc_w, 16'hFFFF);
    @(negedge clk);
    rst_w = 1'b0;
    mem_ready_w = 1'b1;
    @(negedge clk);
    check("restart mem_rd", mem_rd_w, 1);
    check("restart mem_addr", mem_addr_w, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
